// File: rtl/imem_arb.sv
// imem_arb: arbiter and line-assembly controller for the single-port
// 256x128 instruction memory.
//
// The port is shared between fetch reads and 32-bit host program-load words.
// Host words are gathered in a four-word line buffer. When the fetch unit
// leaves the port idle, the buffer is committed as one 128-bit write.
// Fetch reads have strict priority over commits.
//
// Optional macro IMEM_ARB_FAIR_EN adds a wait counter. A commit that has been
// denied MAX_WAIT times is then forced, and the colliding fetch read is dropped.
module imem_arb #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ifu_arb_ce,
  input  logic [ADDR_WIDTH-1:0] ifu_arb_addr,
  output logic [127:0]          arb_ifu_dout,
  output logic                  arb_ifu_dvld,
  output logic                  arb_ifu_stall,
  input  logic                  hst_arb_vld,
  input  logic [ADDR_WIDTH+1:0] hst_arb_addr,
  input  logic [31:0]           hst_arb_wdata,
  input  logic                  hst_arb_flush,
  output logic                  arb_hst_rdy,
  output logic                  arb_hst_busy,
  output logic                  mem_ce,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [127:0]          mem_din,
  input  logic [127:0]          mem_dout
);

  typedef enum logic [1:0] {IDLE, FILL, PEND} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   tag;
  logic [127:0]            line_buf;
  logic [3:0]              mask;
  logic                    skid_vld;
  logic [ADDR_WIDTH+1:0]   skid_addr;
  logic [31:0]             skid_data;

  logic                    word_acc;
  logic                    flush_acc;
  logic                    commit;
  logic                    force_commit;
  logic [ADDR_WIDTH-1:0]   word_line;
  logic [1:0]              word_idx;
  logic [ADDR_WIDTH-1:0]   skid_line;
  logic [1:0]              skid_idx;

  // Builds a line that holds a single word at the given index.
  function automatic logic [127:0] place_word(input logic [1:0] idx,
                                              input logic [31:0] data);
    logic [127:0] line;
    line = '0;
    line[{idx, 5'd0} +: 32] = data;
    return line;
  endfunction

  assign word_line = hst_arb_addr[ADDR_WIDTH+1:2];
  assign word_idx  = hst_arb_addr[1:0];
  assign skid_line = skid_addr[ADDR_WIDTH+1:2];
  assign skid_idx  = skid_addr[1:0];

  assign arb_hst_rdy  = (state != PEND);
  assign arb_hst_busy = (state != IDLE) | skid_vld;
  assign word_acc     = hst_arb_vld & arb_hst_rdy;
  assign flush_acc    = hst_arb_flush & ~hst_arb_vld & arb_hst_rdy;

  // A commit takes the port when fetch is idle, or when the wait limit forces it.
  assign commit = (state == PEND) & (~ifu_arb_ce | force_commit);

  // Memory port: a commit write, otherwise a fetch read.
  always_comb begin
    mem_ce   = ifu_arb_ce | commit;
    mem_we   = commit;
    mem_addr = commit ? tag : ifu_arb_addr;
    mem_din  = '0;
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) mem_din[32*k +: 32] = line_buf[32*k +: 32];
    end
  end

  assign arb_ifu_dout = mem_dout;

`ifdef IMEM_ARB_FAIR_EN
  localparam int CW = $clog2(MAX_WAIT) + 1;
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt;

  assign force_commit  = (state == PEND) & (wait_cnt == WAIT_LIMIT);
  assign arb_ifu_stall = force_commit & ifu_arb_ce;

  // Count PEND cycles in which the commit lost the port to a fetch read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (commit) begin
      wait_cnt <= '0;
    end else if (state == PEND && ifu_arb_ce) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  logic unused_max_wait;
  assign unused_max_wait = (MAX_WAIT != 0);
  assign force_commit    = 1'b0;
  assign arb_ifu_stall   = 1'b0;
`endif

  // Read data is valid one cycle after a granted fetch read. Dropped reads stay invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) arb_ifu_dvld <= 1'b0;
    else        arb_ifu_dvld <= ifu_arb_ce & ~arb_ifu_stall;
  end

  // Line-assembly state machine: fill, hand-off to PEND, commit, then reload from the skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tag       <= '0;
      line_buf  <= '0;
      mask      <= '0;
      skid_vld  <= 1'b0;
      skid_addr <= '0;
      skid_data <= '0;
    end else if (commit) begin
      if (skid_vld) begin
        line_buf <= place_word(skid_idx, skid_data);
        mask     <= 4'b0001 << skid_idx;
        tag      <= skid_line;
        skid_vld <= 1'b0;
        state    <= (skid_idx == 2'd3) ? PEND : FILL;
      end else begin
        line_buf <= '0;
        mask     <= '0;
        state    <= IDLE;
      end
    end else begin
      case (state)
        IDLE: begin
          if (word_acc) begin
            line_buf[{word_idx, 5'd0} +: 32] <= hst_arb_wdata;
            mask[word_idx] <= 1'b1;
            tag            <= word_line;
            state          <= (word_idx == 2'd3) ? PEND : FILL;
          end
        end
        FILL: begin
          if (word_acc) begin
            if (word_line == tag) begin
              line_buf[{word_idx, 5'd0} +: 32] <= hst_arb_wdata;
              mask[word_idx] <= 1'b1;
              if (word_idx == 2'd3) state <= PEND;
            end else begin
              skid_vld  <= 1'b1;
              skid_addr <= hst_arb_addr;
              skid_data <= hst_arb_wdata;
              state     <= PEND;
            end
          end else if (flush_acc) begin
            state <= PEND;
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_arb.sv
// Directed testbench for imem_arb, with a behavioural 256x128 memory attached.
module tb_imem_arb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ifu_arb_ce;
  logic [7:0]   ifu_arb_addr;
  logic [127:0] arb_ifu_dout;
  logic         arb_ifu_dvld;
  logic         arb_ifu_stall;
  logic         hst_arb_vld;
  logic [9:0]   hst_arb_addr;
  logic [31:0]  hst_arb_wdata;
  logic         hst_arb_flush;
  logic         arb_hst_rdy;
  logic         arb_hst_busy;
  logic         mem_ce;
  logic         mem_we;
  logic [7:0]   mem_addr;
  logic [127:0] mem_din;
  logic [127:0] mem_dout;

  int vectors = 0;
  int miscompares = 0;
  int we_count = 0;
  int we_before;

  logic [127:0] mem [256];

  imem_arb #(.ADDR_WIDTH(8), .MAX_WAIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_arb_ce(ifu_arb_ce), .ifu_arb_addr(ifu_arb_addr),
    .arb_ifu_dout(arb_ifu_dout), .arb_ifu_dvld(arb_ifu_dvld),
    .arb_ifu_stall(arb_ifu_stall),
    .hst_arb_vld(hst_arb_vld), .hst_arb_addr(hst_arb_addr),
    .hst_arb_wdata(hst_arb_wdata), .hst_arb_flush(hst_arb_flush),
    .arb_hst_rdy(arb_hst_rdy), .arb_hst_busy(arb_hst_busy),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
  end

  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_din;
        we_count <= we_count + 1;
      end else begin
        mem_dout <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic host_word(input logic [7:0] line, input logic [1:0] idx, input logic [31:0] data);
    hst_arb_vld   = 1'b1;
    hst_arb_addr  = {line, idx};
    hst_arb_wdata = data;
    cyc();
    hst_arb_vld = 1'b0;
  endtask

  task automatic flush();
    hst_arb_flush = 1'b1;
    cyc();
    hst_arb_flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ifu_arb_ce = 1'b0; ifu_arb_addr = '0; mem_dout = '0;
    hst_arb_vld = 1'b0; hst_arb_addr = '0; hst_arb_wdata = '0; hst_arb_flush = 1'b0;
    cyc(); cyc();
    chk("rst_rdy",   128'(arb_hst_rdy),   128'(1));
    chk("rst_busy",  128'(arb_hst_busy),  128'(0));
    chk("rst_we",    128'(mem_we),        128'(0));
    chk("rst_stall", 128'(arb_ifu_stall), 128'(0));
    chk("rst_dvld",  128'(arb_ifu_dvld),  128'(0));
    rst_n = 1'b1;
    cyc();

    // Full line 0x05, committed on the cycle after word 3 is accepted.
    host_word(8'h05, 2'd0, 32'h11);
    host_word(8'h05, 2'd1, 32'h22);
    host_word(8'h05, 2'd2, 32'h33);
    host_word(8'h05, 2'd3, 32'h44);
    #1;
    chk("t1_rdy",  128'(arb_hst_rdy), 128'(0));
    chk("t1_we",   128'(mem_we),      128'(1));
    chk("t1_addr", 128'(mem_addr),    128'(8'h05));
    chk("t1_din",  mem_din, 128'h00000044_00000033_00000022_00000011);
    cyc();
    chk("t1_busy", 128'(arb_hst_busy), 128'(0));
    chk("t1_we0",  128'(mem_we),       128'(0));

    // Partial line 0x10 committed by flush, then read back by fetch.
    host_word(8'h10, 2'd0, 32'hA0);
    host_word(8'h10, 2'd1, 32'hA1);
    flush();
    #1;
    chk("t2_we",   128'(mem_we),   128'(1));
    chk("t2_addr", 128'(mem_addr), 128'(8'h10));
    chk("t2_din",  mem_din, {64'h0, 32'hA1, 32'hA0});
    cyc();
    chk("t2_busy", 128'(arb_hst_busy), 128'(0));
    ifu_arb_ce = 1'b1; ifu_arb_addr = 8'h10;
    #1;
    chk("t2_rd_ce",   128'(mem_ce),   128'(1));
    chk("t2_rd_we",   128'(mem_we),   128'(0));
    chk("t2_rd_addr", 128'(mem_addr), 128'(8'h10));
    cyc();
    ifu_arb_ce = 1'b0;
    #1;
    chk("t2_dvld", 128'(arb_ifu_dvld), 128'(1));
    chk("t2_dout", arb_ifu_dout, {64'h0, 32'hA1, 32'hA0});
    cyc();

    // Line 0x01 interrupted by a line 0x02 word: the new word goes to the skid.
    host_word(8'h01, 2'd0, 32'hB0);
    host_word(8'h01, 2'd1, 32'hB1);
    host_word(8'h02, 2'd0, 32'hC0);
    #1;
    chk("t3_rdy",  128'(arb_hst_rdy),  128'(0));
    chk("t3_busy", 128'(arb_hst_busy), 128'(1));
    chk("t3_we",   128'(mem_we),       128'(1));
    chk("t3_addr", 128'(mem_addr),     128'(8'h01));
    chk("t3_din",  mem_din, {64'h0, 32'hB1, 32'hB0});
    cyc();
    chk("t3_fill_rdy",  128'(arb_hst_rdy),  128'(1));
    chk("t3_fill_busy", 128'(arb_hst_busy), 128'(1));
    chk("t3_fill_we",   128'(mem_we),       128'(0));
    flush();
    #1;
    chk("t3_tag2_addr", 128'(mem_addr), 128'(8'h02));
    chk("t3_tag2_din",  mem_din, {96'h0, 32'hC0});
    cyc();

    // Line 0x03 in PEND while fetch reads line 0x05 for five cycles.
    host_word(8'h03, 2'd0, 32'hD0);
    host_word(8'h03, 2'd1, 32'hD1);
    host_word(8'h03, 2'd2, 32'hD2);
    host_word(8'h03, 2'd3, 32'hD3);
    ifu_arb_ce = 1'b1; ifu_arb_addr = 8'h05;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_we",  128'(mem_we),      128'(0));
      chk("t4_rdy", 128'(arb_hst_rdy), 128'(0));
      if (i > 0) chk("t4_dvld", 128'(arb_ifu_dvld), 128'(1));
      cyc();
    end
    ifu_arb_ce = 1'b0;
    #1;
    chk("t4_dvld_last", 128'(arb_ifu_dvld), 128'(1));
    chk("t4_dout", arb_ifu_dout, 128'h00000044_00000033_00000022_00000011);
    chk("t4_we1",   128'(mem_we),   128'(1));
    chk("t4_addr",  128'(mem_addr), 128'(8'h03));
    chk("t4_din",   mem_din, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
    cyc();

    // Commit starved by continuous fetch: forced after MAX_WAIT denials when fair mode is built in.
    host_word(8'h07, 2'd3, 32'h77);
    ifu_arb_ce = 1'b1; ifu_arb_addr = 8'h05;
`ifdef IMEM_ARB_FAIR_EN
    for (int i = 1; i <= 9; i++) begin
      #1;
      chk("t5_we",    128'(mem_we),        128'(i == 9));
      chk("t5_stall", 128'(arb_ifu_stall), 128'(i == 9));
      if (i == 9) begin
        chk("t5_addr", 128'(mem_addr), 128'(8'h07));
        chk("t5_din",  mem_din, {32'h77, 96'h0});
      end
      cyc();
    end
    #1;
    chk("t5_dvld0", 128'(arb_ifu_dvld), 128'(0));
    chk("t5_busy",  128'(arb_hst_busy), 128'(0));
    ifu_arb_ce = 1'b0;
    cyc();
`else
    for (int i = 1; i <= 12; i++) begin
      #1;
      chk("t5_we",    128'(mem_we),        128'(0));
      chk("t5_stall", 128'(arb_ifu_stall), 128'(0));
      cyc();
    end
    ifu_arb_ce = 1'b0;
    #1;
    chk("t5_we1",  128'(mem_we),   128'(1));
    chk("t5_addr", 128'(mem_addr), 128'(8'h07));
    chk("t5_din",  mem_din, {32'h77, 96'h0});
    cyc();
`endif

    // Reset in FILL with two words buffered discards the line without writing memory.
    host_word(8'h20, 2'd0, 32'hE0);
    host_word(8'h20, 2'd1, 32'hE1);
    chk("t6_busy_fill", 128'(arb_hst_busy), 128'(1));
    we_before = we_count;
    rst_n = 1'b0;
    #1;
    chk("t6_busy_rst", 128'(arb_hst_busy), 128'(0));
    cyc(); cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    chk("t6_busy", 128'(arb_hst_busy), 128'(0));
    chk("t6_rdy",  128'(arb_hst_rdy),  128'(1));
    chk("t6_we",   128'(mem_we),       128'(0));
    chk("t6_nowrite", 128'(we_count),  128'(we_before));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
